// File: rtl/uart_packet_sender_pkg.sv
// Shared types and constants for the UART packet sender: FSM states, byte
// phases and the checksum accumulate helper.
package uart_packet_sender_pkg;

    typedef enum logic [2:0] {
        UPS_IDLE     = 3'd0,
        UPS_LOAD     = 3'd1,
        UPS_WAIT_RDY = 3'd2,
        UPS_STROBE   = 3'd3,
        UPS_WAIT_ACK = 3'd4,
        UPS_WAIT_FIN = 3'd5,
        UPS_DONE     = 3'd6
    } ups_state_e;

    typedef enum logic [1:0] {
        PH_HDR  = 2'd0,
        PH_PAY  = 2'd1,
        PH_CSUM = 2'd2
    } ups_phase_e;

    localparam logic [7:0] UPS_HDR_DEFAULT = 8'hA5;

    // Checksum is a plain modulo-256 sum; overflow wraps silently.
    function automatic logic [7:0] csum_add(input logic [7:0] acc, input logic [7:0] b);
        return acc + b;
    endfunction

endpackage

// File: rtl/uart_packet_sender_byte_mux.sv
// Combinational selection of the byte to transmit: header constant, payload
// byte (MSB first, indexed by idx_i) or the running checksum.
module ups_byte_mux
    import uart_packet_sender_pkg::*;
#(
    parameter int         DATA_W   = 32,
    parameter int         IDX_W    = 2,
    parameter logic [7:0] HDR_BYTE = UPS_HDR_DEFAULT
) (
    input  ups_phase_e        phase_i,
    input  logic [IDX_W-1:0]  idx_i,
    input  logic [DATA_W-1:0] payload_i,
    input  logic [7:0]        csum_i,
    output logic [7:0]        byte_o
);

    localparam int NBYTES = DATA_W / 8;

    logic [NBYTES-1:0][7:0] bytes_w;
    logic [7:0]             pay_byte_w;

    assign bytes_w = payload_i;

    // idx 0 is the most significant byte.
    always_comb begin
        pay_byte_w = 8'h00;
        for (int i = 0; i < NBYTES; i++) begin
            if (idx_i == IDX_W'(NBYTES - 1 - i)) pay_byte_w = bytes_w[i];
        end
    end

    always_comb begin
        case (phase_i)
            PH_HDR:  byte_o = HDR_BYTE;
            PH_PAY:  byte_o = pay_byte_w;
            default: byte_o = csum_i;
        endcase
    end

endmodule

// File: rtl/uart_packet_sender.sv
// Streams a latched DATA_W payload to uart_transmit as [header] bytes MSB-first
// [checksum], one send strobe per byte with an acknowledge timeout.
module uart_packet_sender
    import uart_packet_sender_pkg::*;
#(
    parameter int         DATA_W   = 32,
    parameter bit         HDR_EN   = 1'b1,
    parameter logic [7:0] HDR_BYTE = UPS_HDR_DEFAULT,
    parameter bit         CSUM_EN  = 1'b1,
    parameter int         ACK_TO   = 1023
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [DATA_W-1:0] payload,
    output logic              busy,
    output logic              done,
    output logic              err,
    output logic              tx_send,
    output logic [7:0]        tx_data,
    input  logic              tx_ready
);

    localparam int NBYTES = DATA_W / 8;
    localparam int IDX_W  = (NBYTES > 1) ? $clog2(NBYTES) : 1;
    localparam int CNT_W  = (ACK_TO > 0) ? $clog2(ACK_TO + 1) : 1;
    localparam ups_phase_e FIRST_PH = HDR_EN ? PH_HDR : PH_PAY;

    ups_state_e        state_q,   state_d;
    ups_phase_e        phase_q,   phase_d;
    logic [DATA_W-1:0] payload_q, payload_d;
    logic [IDX_W-1:0]  idx_q,     idx_d;
    logic [7:0]        csum_q,    csum_d;
    logic [CNT_W-1:0]  cnt_q,     cnt_d;
    logic [7:0]        tx_data_q, tx_data_d;
    logic              tx_send_q, tx_send_d;
    logic              busy_q,    busy_d;
    logic              done_q,    done_d;
    logic              err_q,     err_d;

    logic [7:0] mux_byte_w;
    logic       last_pay_w;
    logic       last_w;

    ups_byte_mux #(
        .DATA_W   (DATA_W),
        .IDX_W    (IDX_W),
        .HDR_BYTE (HDR_BYTE)
    ) u_byte_mux (
        .phase_i   (phase_q),
        .idx_i     (idx_q),
        .payload_i (payload_q),
        .csum_i    (csum_q),
        .byte_o    (mux_byte_w)
    );

    assign last_pay_w = (phase_q == PH_PAY) && (idx_q == IDX_W'(NBYTES - 1));
    assign last_w     = (phase_q == PH_CSUM) || (last_pay_w && !CSUM_EN);

    always_comb begin
        state_d   = state_q;
        phase_d   = phase_q;
        payload_d = payload_q;
        idx_d     = idx_q;
        csum_d    = csum_q;
        cnt_d     = cnt_q;
        tx_data_d = tx_data_q;
        busy_d    = busy_q;
        err_d     = err_q;
        tx_send_d = 1'b0;
        done_d    = 1'b0;

        case (state_q)
            UPS_IDLE: begin
                if (start) begin
                    payload_d = payload;
                    idx_d     = '0;
                    phase_d   = FIRST_PH;
                    csum_d    = 8'h00;
                    err_d     = 1'b0;
                    busy_d    = 1'b1;
                    state_d   = UPS_LOAD;
                end
            end
            UPS_LOAD: begin
                tx_data_d = mux_byte_w;
                state_d   = UPS_WAIT_RDY;
            end
            UPS_WAIT_RDY: begin
                // No timeout here: uart_transmit may still be finishing an earlier byte.
                if (tx_ready) begin
                    tx_send_d = 1'b1;
                    state_d   = UPS_STROBE;
                end
            end
            UPS_STROBE: begin
                if (phase_q != PH_CSUM) csum_d = csum_add(csum_q, tx_data_q);
                cnt_d   = '0;
                state_d = UPS_WAIT_ACK;
            end
            UPS_WAIT_ACK: begin
                if (!tx_ready) begin
                    state_d = UPS_WAIT_FIN;
                end else if (cnt_q == CNT_W'(ACK_TO)) begin
                    err_d   = 1'b1;
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                    state_d = UPS_DONE;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            UPS_WAIT_FIN: begin
                if (tx_ready) begin
                    if (last_w) begin
                        busy_d  = 1'b0;
                        done_d  = 1'b1;
                        state_d = UPS_DONE;
                    end else begin
                        if (phase_q == PH_HDR) begin
                            phase_d = PH_PAY;
                            idx_d   = '0;
                        end else if (last_pay_w) begin
                            phase_d = PH_CSUM;
                        end else begin
                            idx_d = idx_q + IDX_W'(1);
                        end
                        state_d = UPS_LOAD;
                    end
                end
            end
            UPS_DONE: begin
                state_d = UPS_IDLE;
            end
            default: begin
                state_d = UPS_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= UPS_IDLE;
            phase_q   <= PH_HDR;
            payload_q <= '0;
            idx_q     <= '0;
            csum_q    <= 8'h00;
            cnt_q     <= '0;
            tx_data_q <= 8'h00;
            tx_send_q <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            phase_q   <= phase_d;
            payload_q <= payload_d;
            idx_q     <= idx_d;
            csum_q    <= csum_d;
            cnt_q     <= cnt_d;
            tx_data_q <= tx_data_d;
            tx_send_q <= tx_send_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            err_q     <= err_d;
        end
    end

    assign busy    = busy_q;
    assign done    = done_q;
    assign err     = err_q;
    assign tx_send = tx_send_q;
    assign tx_data = tx_data_q;

endmodule

// File: tb/tb_uart_packet_sender.sv
// Bench for uart_packet_sender: a uart_transmit model (ready low 10 cycles per
// byte) feeds a byte scoreboard; table vectors plus hand-written corner cases.
module tb_uart_packet_sender;

    localparam int ACK_TO = 40;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [31:0] payload;
    logic        busy, done, err, tx_send;
    logic [7:0]  tx_data;
    logic        m_rdy = 1'b1;

    logic        s_start;
    logic [7:0]  s_payload;
    logic        s_busy, s_done, s_err, s_send;
    logic [7:0]  s_data;
    logic        s_rdy = 1'b1;

    always #5 clk = ~clk;

    uart_packet_sender #(
        .DATA_W(32), .HDR_EN(1'b1), .HDR_BYTE(8'hA5), .CSUM_EN(1'b1), .ACK_TO(ACK_TO)
    ) dut (
        .clk(clk), .rst(rst), .start(start), .payload(payload),
        .busy(busy), .done(done), .err(err),
        .tx_send(tx_send), .tx_data(tx_data), .tx_ready(m_rdy)
    );

    uart_packet_sender #(
        .DATA_W(8), .HDR_EN(1'b0), .HDR_BYTE(8'hA5), .CSUM_EN(1'b0), .ACK_TO(ACK_TO)
    ) dut8 (
        .clk(clk), .rst(rst), .start(s_start), .payload(s_payload),
        .busy(s_busy), .done(s_done), .err(s_err),
        .tx_send(s_send), .tx_data(s_data), .tx_ready(s_rdy)
    );

    int checks = 0;
    int errors = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // ---------------- uart_transmit model + scoreboard ----------------
    logic [7:0] exp_q[$];
    int         m_strobes = 0, m_cnt = 0, ign_n = 0;
    int         cyc = 0, ign_cyc = 0, done_cyc = 0, done_cnt = 0;
    int         stable_bad = 0, overlap_bad = 0;
    logic [7:0] m_hold = 8'h00;

    always @(posedge clk) cyc++;

    always @(negedge clk) begin
        if (done) begin
            done_cnt++;
            done_cyc = cyc;
        end
        if (tx_send) begin
            m_strobes++;
            if (!m_rdy) overlap_bad++;
            if (m_strobes == ign_n) begin
                ign_cyc = cyc;            // never acknowledged: ready stays high
            end else begin
                m_rdy  = 1'b0;
                m_cnt  = 10;
                m_hold = tx_data;
                if (exp_q.size() == 0) chk("sb_unexpected_byte", {24'h0, tx_data}, 32'hFFFF_FFFF);
                else                   chk("tx_byte", {24'h0, tx_data}, {24'h0, exp_q.pop_front()});
            end
        end else if (m_cnt > 0) begin
            if (busy && tx_data !== m_hold) stable_bad++;
            m_cnt--;
            if (m_cnt == 0) m_rdy = 1'b1;
        end
    end

    int         s_strobes = 0, s_cnt = 0;
    logic [7:0] s_last = 8'h00;

    always @(negedge clk) begin
        if (s_send) begin
            s_strobes++;
            s_last = s_data;
            s_rdy  = 1'b0;
            s_cnt  = 10;
        end else if (s_cnt > 0) begin
            s_cnt--;
            if (s_cnt == 0) s_rdy = 1'b1;
        end
    end

    // ---------------- helpers ----------------
    function automatic logic [7:0] model_csum(input logic [31:0] p);
        logic [7:0] s;
        s = 8'hA5;
        for (int i = 0; i < 4; i++) s = s + p[8*i +: 8];
        return s;
    endfunction

    task automatic push_pkt(input logic [31:0] p, input logic [7:0] cs);
        exp_q.push_back(8'hA5);
        for (int i = 3; i >= 0; i--) exp_q.push_back(p[8*i +: 8]);
        exp_q.push_back(cs);
    endtask

    task automatic pulse_start(input logic [31:0] p);
        @(negedge clk);
        payload = p;
        start   = 1'b1;
        @(negedge clk);
        start   = 1'b0;
    endtask

    // Returns at the negedge where done is seen (or when the budget expires).
    task automatic wait_done(input int budget, input bit noise, output bit seen, output bit busy_bad);
        int n = 0;
        seen = 1'b0;
        busy_bad = 1'b0;
        while (n < budget) begin
            if (done) begin
                seen  = 1'b1;
                start = 1'b0;
                break;
            end
            if (!busy) busy_bad = 1'b1;
            if (noise) begin
                start   = (n % 3 == 1);
                payload = $urandom;
            end
            @(negedge clk);
            n++;
        end
        start = 1'b0;
    endtask

    task automatic run_pkt(input string nm, input logic [31:0] p, input logic [7:0] cs, input bit noise);
        int d0, s0;
        bit seen, bb;
        push_pkt(p, cs);
        d0 = done_cnt;
        s0 = m_strobes;
        pulse_start(p);
        wait_done(400, noise, seen, bb);
        @(negedge clk);
        chk({nm, "_done_seen"}, seen, 1);
        chk({nm, "_busy_thru"}, bb, 0);
        chk({nm, "_done_1cyc"}, done, 0);
        chk({nm, "_done_cnt"}, done_cnt - d0, 1);
        chk({nm, "_strobes"}, m_strobes - s0, 6);
        chk({nm, "_sb_drained"}, exp_q.size(), 0);
        chk({nm, "_err"}, err, 0);
    endtask

    typedef struct {
        logic [31:0] pay;
        logic [7:0]  csum;
    } vec_t;

    vec_t vecs[5];

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        bit seen, bb;
        int d0, s0, n, lat;

        vecs[0] = '{32'h01020304, 8'hAF};
        vecs[1] = '{32'hFFFFFFFF, 8'hA1};
        vecs[2] = '{32'h00000000, 8'hA5};
        vecs[3] = '{32'h12345678, 8'hB9};
        vecs[4] = '{32'h5B5B5B5B, 8'h11};

        rst = 1'b1; start = 1'b0; payload = '0; s_start = 1'b0; s_payload = '0;
        repeat (3) @(negedge clk);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_err", err, 0);
        chk("rst_tx_send", tx_send, 0);
        chk("rst_tx_data", tx_data, 0);
        rst = 1'b0;
        @(negedge clk);

        foreach (vecs[i]) run_pkt($sformatf("vec%0d", i), vecs[i].pay, vecs[i].csum, 1'b0);

        // Acknowledge never arrives for the 2nd byte: timeout, err, done, no 3rd strobe.
        exp_q.push_back(8'hA5);
        d0 = done_cnt;
        s0 = m_strobes;
        ign_n = m_strobes + 2;
        pulse_start(32'hCAFEBABE);
        wait_done(ACK_TO + 300, 1'b0, seen, bb);
        @(negedge clk);
        chk("to_done_seen", seen, 1);
        chk("to_err", err, 1);
        chk("to_done_cnt", done_cnt - d0, 1);
        chk("to_strobes", m_strobes - s0, 2);
        chk("to_sb_drained", exp_q.size(), 0);
        chk("to_time_in_range", (done_cyc - ign_cyc >= ACK_TO + 1) && (done_cyc - ign_cyc <= ACK_TO + 3), 1);
        repeat (5) @(negedge clk);
        chk("to_err_sticky", err, 1);
        ign_n = 0;
        push_pkt(32'h0A0B0C0D, model_csum(32'h0A0B0C0D));
        pulse_start(32'h0A0B0C0D);
        chk("to_err_cleared", err, 0);
        wait_done(400, 1'b0, seen, bb);
        @(negedge clk);
        chk("to_next_done", seen, 1);
        chk("to_next_sb", exp_q.size(), 0);

        // start spam and payload changes while busy must not disturb the packet.
        run_pkt("noise", 32'hDEADBEEF, model_csum(32'hDEADBEEF), 1'b1);

        // start held through the DONE cycle is ignored, accepted on the cycle after.
        push_pkt(32'h11223344, model_csum(32'h11223344));
        pulse_start(32'h11223344);
        wait_done(400, 1'b0, seen, bb);
        chk("bnd_done_seen", seen, 1);
        push_pkt(32'h55667788, model_csum(32'h55667788));
        payload = 32'h55667788;
        start   = 1'b1;
        @(negedge clk);
        chk("bnd_ignored_in_done", busy, 0);
        @(negedge clk);
        chk("bnd_accepted_after", busy, 1);
        start = 1'b0;
        wait_done(400, 1'b0, seen, bb);
        @(negedge clk);
        chk("bnd_second_done", seen, 1);
        chk("bnd_sb_drained", exp_q.size(), 0);

        // Reset during WAIT_FIN of byte 3.
        push_pkt(32'h99887766, model_csum(32'h99887766));
        s0 = m_strobes;
        pulse_start(32'h99887766);
        n = 0;
        while (m_strobes < s0 + 3 && n < 200) begin
            @(negedge clk);
            n++;
        end
        chk("rstmid_reached_byte3", m_strobes - s0, 3);
        repeat (3) @(negedge clk);
        d0 = done_cnt;
        rst = 1'b1;
        @(negedge clk);
        chk("rstmid_busy", busy, 0);
        chk("rstmid_tx_send", tx_send, 0);
        chk("rstmid_tx_data", tx_data, 0);
        chk("rstmid_err_done", {err, done}, 0);
        rst = 1'b0;
        exp_q.delete();
        n = 0;
        while (!m_rdy && n < 50) begin
            @(negedge clk);
            n++;
        end
        repeat (3) @(negedge clk);
        chk("rstmid_no_done", done_cnt - d0, 0);
        run_pkt("after_rst", 32'h0F1E2D3C, model_csum(32'h0F1E2D3C), 1'b0);

        // Degenerate single-byte configuration.
        s0 = s_strobes;
        @(negedge clk);
        s_payload = 8'h5C;
        s_start   = 1'b1;
        lat = 0;
        @(negedge clk);
        s_start = 1'b0;
        lat = 1;
        while (!s_send && lat < 20) begin
            @(negedge clk);
            lat++;
        end
        chk("b8_latency", lat, 3);
        n = 0;
        while (!s_done && n < 100) begin
            @(negedge clk);
            n++;
        end
        chk("b8_done_seen", s_done, 1);
        chk("b8_strobes", s_strobes - s0, 1);
        chk("b8_byte", s_last, 8'h5C);
        chk("b8_err", s_err, 0);
        @(negedge clk);
        chk("b8_busy_after", s_busy, 0);

        chk("tx_data_stable", stable_bad, 0);
        chk("no_send_while_busy", overlap_bad, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
